// File: rtl/pulse_scheduler.sv
// Two-requester round-robin scheduler that shares one programmable pulse timer.
// Each granted job emits count one-cycle pulses spaced period+1 cycles apart, then a one-cycle done.
module pulse_scheduler #(
  parameter int unsigned PER_W = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req,
  input  logic [PER_W-1:0] i_period0,
  input  logic [PER_W-1:0] i_period1,
  input  logic [CNT_W-1:0] i_count0,
  input  logic [CNT_W-1:0] i_count1,
  input  logic             i_abort,
  output logic [1:0]       o_grant,
  output logic             o_busy,
  output logic             o_owner,
  output logic             o_pulse,
  output logic [1:0]       o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PER_W-1:0] r_timer, w_timer_nxt;
  logic [PER_W-1:0] r_per, w_per_nxt;
  logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
  logic             r_owner, w_owner_nxt;
  logic             r_last, w_last_nxt;
  logic             r_first, w_first_nxt;

  logic             w_win_valid;
  logic             w_win_idx;
  logic [PER_W-1:0] w_win_period;
  logic [CNT_W-1:0] w_win_count;
  logic             w_timer_zero;
  logic             w_rem_zero;
  logic             w_rem_one;
  logic [1:0]       w_owner_onehot;

  // Arbitration: a lone request wins outright; on contention the requester
  // that was not served last wins.
  always_comb begin
    w_win_valid = |i_req;
    w_win_idx   = 1'b0;
    unique case (i_req)
      2'b01:   w_win_idx = 1'b0;
      2'b10:   w_win_idx = 1'b1;
      2'b11:   w_win_idx = ~r_last;
      default: w_win_idx = 1'b0;
    endcase
    w_win_period = w_win_idx ? i_period1 : i_period0;
    w_win_count  = w_win_idx ? i_count1  : i_count0;
  end

  assign w_timer_zero   = (r_timer == '0);
  assign w_rem_zero     = (r_remaining == '0);
  assign w_rem_one      = (r_remaining == CNT_W'(1));
  assign w_owner_onehot = r_owner ? 2'b10 : 2'b01;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_per       <= '0;
      r_remaining <= '0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_first     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_per       <= w_per_nxt;
      r_remaining <= w_remaining_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_first     <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_per_nxt       = r_per;
    w_remaining_nxt = r_remaining;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    w_first_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_state_nxt     = S_RUN;
          w_per_nxt       = w_win_period;
          w_timer_nxt     = w_win_period;
          w_remaining_nxt = w_win_count;
          w_owner_nxt     = w_win_idx;
          w_last_nxt      = w_win_idx;
          w_first_nxt     = 1'b1;
        end
      end
      // Priority: abort, empty job, countdown, then pulse with reload or finish.
      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_rem_zero) begin
          w_state_nxt = S_DONE;
        end else if (!w_timer_zero) begin
          w_timer_nxt = r_timer - PER_W'(1);
        end else if (w_rem_one) begin
          w_state_nxt = S_DONE;
        end else begin
          w_remaining_nxt = r_remaining - CNT_W'(1);
          w_timer_nxt     = r_per;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Only pulse looks at an input (abort), so an aborted pulse cycle stays quiet.
  always_comb begin
    o_busy  = (r_state == S_RUN);
    o_owner = r_owner;
    o_grant = (r_state == S_RUN && r_first) ? w_owner_onehot : 2'b00;
    o_pulse = (r_state == S_RUN) && w_timer_zero && !w_rem_zero && !i_abort;
    o_done  = (r_state == S_DONE) ? w_owner_onehot : 2'b00;
  end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: expected grant/busy/pulse/done/owner per cycle
// are derived from the job timing formulas (pulses at 1+p+k*(p+1), busy for count*(p+1)).
module tb_pulse_scheduler;

  localparam int unsigned PER_W = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [PER_W-1:0] period0, period1;
  logic [CNT_W-1:0] count0, count1;
  logic             abort;
  logic [1:0]       grant;
  logic             busy;
  logic             owner;
  logic             pulse;
  logic [1:0]       done;

  int tests = 0;
  int fails = 0;

  pulse_scheduler #(.PER_W(PER_W), .CNT_W(CNT_W)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_req    (req),
    .i_period0(period0),
    .i_period1(period1),
    .i_count0 (count0),
    .i_count1 (count1),
    .i_abort  (abort),
    .o_grant  (grant),
    .o_busy   (busy),
    .o_owner  (owner),
    .o_pulse  (pulse),
    .o_done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] g, input logic b,
                         input logic p, input logic [1:0] d);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".pulse"}, 32'(pulse), 32'(p));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where the winning req is sampled; checks every
  // cycle through the IDLE cycle that follows done.
  task automatic run_job(input logic idx, input int per, input int cnt, input bit keep);
    int       len;
    logic [1:0] oh;
    logic     exp_p;
    logic     exp_b;
    logic [1:0] exp_g;
    logic [1:0] exp_d;
    len = (cnt == 0) ? 1 : cnt * (per + 1);
    oh  = idx ? 2'b10 : 2'b01;
    for (int c = 1; c <= len + 2; c++) begin
      tick;
      exp_p = 1'b0;
      for (int k = 0; k < cnt; k++)
        if (c == 1 + per + k * (per + 1)) exp_p = 1'b1;
      exp_g = (c == 1) ? oh : 2'b00;
      exp_b = (c <= len);
      exp_d = (c == len + 1) ? oh : 2'b00;
      chk_out($sformatf("job%0d_p%0d_n%0d_c%0d", idx, per, cnt, c), exp_g, exp_b, exp_p, exp_d);
      if (exp_b || exp_d != 2'b00)
        chk($sformatf("job%0d_c%0d.owner", idx, c), 32'(owner), 32'(idx));
      if (c == 1 && !keep) req = 2'b00;
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    req   = 2'b00;
    abort = 1'b0;
    tick;
    chk_out(tag, 2'b00, 1'b0, 1'b0, 2'b00);
    chk({tag, ".owner"}, 32'(owner), 32'(0));
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    req     = 2'b00;
    abort   = 1'b0;
    period0 = '0;
    period1 = '0;
    count0  = '0;
    count1  = '0;
    tick;
    do_reset("reset0");

    // Single job: period 2, count 3 -> pulses at c=3,6,9, done at c=10.
    req = 2'b01; period0 = 8'd2; count0 = 4'd3;
    run_job(1'b0, 2, 3, 1'b0);

    // Contention after reset (last=1): grants alternate 0,1,0.
    do_reset("reset1");
    req = 2'b11; period0 = 8'd1; count0 = 4'd2; period1 = 8'd1; count1 = 4'd2;
    run_job(1'b0, 1, 2, 1'b1);
    run_job(1'b1, 1, 2, 1'b1);
    run_job(1'b0, 1, 2, 1'b0);

    // Empty job: one busy cycle, no pulse, done next.
    req = 2'b01; period0 = 8'd7; count0 = 4'd0;
    run_job(1'b0, 7, 0, 1'b0);

    // Period 0: pulses on four consecutive cycles beginning with grant.
    req = 2'b10; period1 = 8'd0; count1 = 4'd4;
    run_job(1'b1, 0, 4, 1'b0);

    // Maximum period with a single pulse.
    req = 2'b10; period1 = 8'd255; count1 = 4'd1;
    run_job(1'b1, 255, 1, 1'b0);

    // Abort on the second pulse, with requester 1 pending.
    do_reset("reset2");
    req = 2'b11; period0 = 8'd5; count0 = 4'd3; period1 = 8'd1; count1 = 4'd1;
    for (int c = 1; c <= 12; c++) begin
      tick;
      chk_out($sformatf("abortjob_c%0d", c), (c == 1) ? 2'b01 : 2'b00, 1'b1,
              (c == 6 || c == 12), 2'b00);
      if (c == 1) req = 2'b10;
    end
    abort = 1'b1;
    #1;
    chk_out("abort_cycle", 2'b00, 1'b1, 1'b0, 2'b00);
    tick;
    abort = 1'b0;
    chk_out("abort_idle", 2'b00, 1'b0, 1'b0, 2'b00);
    run_job(1'b1, 1, 1, 1'b0);

    // Reset in the middle of a run, then contention must favour requester 0.
    req = 2'b01; period0 = 8'd3; count0 = 4'd4;
    tick;
    chk_out("prereset_grant", 2'b01, 1'b1, 1'b0, 2'b00);
    req = 2'b00;
    for (int c = 2; c <= 5; c++) begin
      tick;
      chk_out($sformatf("prereset_c%0d", c), 2'b00, 1'b1, (c == 4), 2'b00);
    end
    do_reset("reset_midrun");
    req = 2'b11; period0 = 8'd0; count0 = 4'd1; period1 = 8'd2; count1 = 4'd2;
    run_job(1'b0, 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
